// File: rtl/db9md_pkg.sv
// Shared definitions for the DB9 Mega Drive pad scanner: button bit positions,
// raw pin indices and the scan state encoding.
package db9md_pkg;

    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_B     = 4;
    localparam int BTN_C     = 5;
    localparam int BTN_A     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_MODE  = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_Y     = 10;
    localparam int BTN_Z     = 11;

    localparam int JOY_IN_UP    = 0;
    localparam int JOY_IN_DOWN  = 1;
    localparam int JOY_IN_LEFT  = 2;
    localparam int JOY_IN_RIGHT = 3;
    localparam int JOY_IN_PIN6  = 4;
    localparam int JOY_IN_PIN9  = 5;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        PHASE  = 2'd1,
        IDLE   = 2'd2
    } state_t;

endpackage

// File: rtl/db9md_phase_decoder.sv
// Combinational map from (protocol phase, synced raw pins, pad identity flags)
// to the bits of the per-scan shadow word that this phase's sample overwrites.
module db9md_phase_decoder
    import db9md_pkg::*;
(
    input  logic [2:0]  i_ph,
    input  logic [5:0]  i_pins,
    input  logic        i_md_id,
    input  logic        i_six,
    output logic [11:0] o_mask,
    output logic [11:0] o_val,
    output logic        o_md_id_we,
    output logic        o_md_id_val,
    output logic        o_six_we,
    output logic        o_six_val
);

    logic [5:0] w_pr;
    logic       w_md_now;

    assign w_pr     = ~i_pins;
    assign w_md_now = w_pr[JOY_IN_LEFT] & w_pr[JOY_IN_RIGHT];

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        o_mask      = '0;
        o_val       = '0;
        o_md_id_we  = 1'b0;
        o_md_id_val = 1'b0;
        o_six_we    = 1'b0;
        o_six_val   = 1'b0;
        unique case (i_ph)
            // Phase 0 rewrites the whole word, so MD-only buttons start each scan cleared.
            3'd0: begin
                o_mask          = '1;
                o_val[BTN_U]    = w_pr[JOY_IN_UP];
                o_val[BTN_D]    = w_pr[JOY_IN_DOWN];
                o_val[BTN_L]    = w_pr[JOY_IN_LEFT];
                o_val[BTN_R]    = w_pr[JOY_IN_RIGHT];
                o_val[BTN_B]    = w_pr[JOY_IN_PIN6];
                o_val[BTN_C]    = w_pr[JOY_IN_PIN9];
                o_md_id_we      = 1'b1;
                o_six_we        = 1'b1;
            end
            3'd1: begin
                o_md_id_we          = 1'b1;
                o_md_id_val         = w_md_now;
                o_mask[BTN_A]       = 1'b1;
                o_mask[BTN_START]   = 1'b1;
                o_val[BTN_A]        = w_pr[JOY_IN_PIN6] & w_md_now;
                o_val[BTN_START]    = w_pr[JOY_IN_PIN9] & w_md_now;
            end
            3'd5: begin
                o_six_we  = 1'b1;
                o_six_val = i_md_id & w_pr[JOY_IN_UP] & w_pr[JOY_IN_DOWN]
                          & w_pr[JOY_IN_LEFT] & w_pr[JOY_IN_RIGHT];
            end
            3'd6: begin
                if (i_six) begin
                    o_mask[BTN_Z]    = 1'b1;
                    o_mask[BTN_Y]    = 1'b1;
                    o_mask[BTN_X]    = 1'b1;
                    o_mask[BTN_MODE] = 1'b1;
                    o_val[BTN_Z]     = w_pr[JOY_IN_UP];
                    o_val[BTN_Y]     = w_pr[JOY_IN_DOWN];
                    o_val[BTN_X]     = w_pr[JOY_IN_LEFT];
                    o_val[BTN_MODE]  = w_pr[JOY_IN_RIGHT];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/db9md_pad_scanner.sv
// Scans two DB9 Mega Drive / Atari pads through the splitter, one 8-phase
// SELECT sequence per pad, and publishes each pad's word only when its scan completes.
module db9md_pad_scanner
    import db9md_pkg::*;
#(
    parameter int STEP_CYCLES   = 400,
    parameter int SETTLE_CYCLES = 400,
    parameter int IDLE_CYCLES   = 98000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  joy_in,
    output logic        joy_split,
    output logic        joy_mdsel,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic [1:0]  six_button
);

    localparam int MAX_A      = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CYCLES = (IDLE_CYCLES > MAX_A) ? IDLE_CYCLES : MAX_A;
    localparam int CW         = $clog2(MAX_CYCLES);

    localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LAST   = CW'(IDLE_CYCLES - 1);

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]      r_ph, w_ph_nxt;
    logic            r_pad, w_pad_nxt;
    logic            r_split, w_split_nxt;
    logic            w_sample;
    logic            w_commit;

    logic [5:0]      r_joy_s1, r_joy_s2;
    logic [11:0]     r_shadow;
    logic            r_md_id, r_six;
    logic [11:0]     r_joy1, r_joy2;
    logic [1:0]      r_six_out;

    logic [11:0]     w_mask, w_val;
    logic            w_md_id_we, w_md_id_val, w_six_we, w_six_val;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_ph_nxt    = r_ph;
        w_pad_nxt   = r_pad;
        w_split_nxt = r_split;
        w_sample    = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_ph_nxt    = 3'd0;
                    w_state_nxt = PHASE;
                end
            end
            PHASE: begin
                if (r_cnt == STEP_LAST) begin
                    w_sample  = 1'b1;
                    w_cnt_nxt = '0;
                    if (r_ph == 3'd7) begin
                        w_commit = 1'b1;
                        if (!r_pad) begin
                            w_pad_nxt   = 1'b1;
                            w_split_nxt = 1'b1;
                            w_state_nxt = SETTLE;
                        end else begin
                            w_split_nxt = 1'b0;
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_ph_nxt = r_ph + 3'd1;
                    end
                end
            end
            IDLE: begin
                if (r_cnt == IDLE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_pad_nxt   = 1'b0;
                    w_state_nxt = SETTLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = SETTLE;
            end
        endcase
    end

    // NOTE: registered state is written with non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SETTLE;
            r_cnt   <= '0;
            r_ph    <= 3'd0;
            r_pad   <= 1'b0;
            r_split <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ph    <= w_ph_nxt;
            r_pad   <= w_pad_nxt;
            r_split <= w_split_nxt;
        end
    end

    db9md_phase_decoder u_decoder (
        .i_ph        (r_ph),
        .i_pins      (r_joy_s2),
        .i_md_id     (r_md_id),
        .i_six       (r_six),
        .o_mask      (w_mask),
        .o_val       (w_val),
        .o_md_id_we  (w_md_id_we),
        .o_md_id_val (w_md_id_val),
        .o_six_we    (w_six_we),
        .o_six_val   (w_six_val)
    );

    // Phase 7 never writes the shadow, so its sample edge can publish the shadow directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_joy_s1  <= 6'h3F;
            r_joy_s2  <= 6'h3F;
            r_shadow  <= '0;
            r_md_id   <= 1'b0;
            r_six     <= 1'b0;
            r_joy1    <= '0;
            r_joy2    <= '0;
            r_six_out <= 2'b00;
        end else begin
            r_joy_s1 <= joy_in;
            r_joy_s2 <= r_joy_s1;
            if (w_sample) begin
                r_shadow <= (r_shadow & ~w_mask) | (w_val & w_mask);
                if (w_md_id_we) r_md_id <= w_md_id_val;
                if (w_six_we)   r_six   <= w_six_val;
            end
            if (w_commit) begin
                if (r_pad) begin
                    r_joy2       <= r_shadow;
                    r_six_out[1] <= r_six;
                end else begin
                    r_joy1       <= r_shadow;
                    r_six_out[0] <= r_six;
                end
            end
        end
    end

    assign joy_split  = r_split;
    assign joy_mdsel  = (r_state == PHASE) ? ~r_ph[0] : 1'b1;
    assign joystick1  = {4'b0000, r_joy1};
    assign joystick2  = {4'b0000, r_joy2};
    assign six_button = r_six_out;

endmodule
